beat_gen: RTL and testbench
===========================

# beat_gen

Beat (node) timing generator for the hardwired controller. It produces the one-hot machine-cycle beats `w1`/`w2`/`w3` that the controller consumes. It stretches or shortens each instruction cycle according to the controller's `short`/`long` requests. It also handles run start (`qd`), halt (`stop`), single-step mode, and a completed-cycle counter for debug display.

## Interface
- `CNT_W`, default 16: width of the completed-cycle counter.

- `t3`  in  1  system clock; all state updates on rising edge.
- `clr`  in  1  reset, synchronous, active-low.
- `qd`  in  1  start button level; a rising edge starts the beat sequence.
- `step`  in  1  single-step mode; 1 = halt after every completed instruction cycle.
- `short`  in  1  controller request: the current cycle ends after `w1`.
- `long`  in  1  controller request: the current cycle extends to `w3`.
- `stop`  in  1  controller halt request; the sequence halts after the current beat.
- `w1`, `w2`, `w3`  out  1 each  beat outputs; one-hot while running, all 0 when idle.
- `running`  out  1  1 whenever a beat is active.
- `cyc_cnt`  out  CNT_W  count of completed instruction cycles; wraps modulo 2^CNT_W.

## Operation
- FSM states are IDLE, W1, W2 and W3. The outputs are registered decodes of the state: `w1`=(W1), `w2`=(W2), `w3`=(W3), `running`=(state≠IDLE).
- Start detect: register `qd_q` samples `qd` every cycle. The start condition `qd_start` = `qd & ~qd_q`.
- IDLE: on `qd_start`, go to W1. Otherwise stay in IDLE.
- W1: if `stop`, go to IDLE. Else if `short`, the cycle is complete and the next state is W1, or IDLE when `step`=1. Else go to W2.
- W2: if `stop`, go to IDLE. Else if `long`, go to W3. Else the cycle is complete and the next state is W1, or IDLE when `step`=1.
- W3: if `stop`, go to IDLE. Else the cycle is complete and the next state is W1, or IDLE when `step`=1.
- Priority in every beat: `stop` > cycle-end/`step` > `short`/`long` continuation.
- Completed cycle: the FSM leaves the last beat of a cycle, i.e. W1 with `short`, W2 with `~long`, or W3.
  - `cyc_cnt` increments by 1 on every completed cycle, including one that also sees `stop` or `step`.
  - Leaving W1 with `~short` due to `stop`, or W2 with `long` due to `stop`, is not a completed cycle; no increment.
- `cyc_cnt` wraps from 2^CNT_W−1 to 0. It is cleared only by reset.
- `qd_start` is ignored in every state except IDLE.
- `short` and `long` both high in W1: `short` wins, and the cycle ends after W1.
- `long` is sampled only in W2, and `short` only in W1; they are don't-care elsewhere.

## Timing
- Reset (`clr`=0 at a `t3` edge):
  - state=IDLE, so `w1`=`w2`=`w3`=0 and `running`=0.
  - `cyc_cnt`=0.
  - `qd_q`=1, so a button held through reset does not start the sequence. It must be released and pressed again.
- Reset mid-operation forces IDLE at the next edge regardless of beat. A beat in progress is abandoned without a count.
- Start latency: `qd` rises before edge k, with `qd_q`=0 → `w1`=1 after edge k. Each beat lasts exactly one `t3` cycle.
- `short`, `long`, `stop` and `step` are sampled at the `t3` edge that ends the current beat. The controller drives them combinationally from the current beat and `ir` within that cycle.
- Cycle lengths: short = 1 clock (W1), normal = 2 clocks (W1 W2), long = 3 clocks (W1 W2 W3).
- `stop` in beat Wn → all beats 0 after that edge. A restart needs a new `qd` rising edge. The earliest restart is 1 clock after IDLE is entered, since `qd_start` needs `qd` low for at least one sampled cycle first.
- `cyc_cnt` updates on the same edge as the transition that completes the cycle.

## Test plan
- Reset/hold: assert `clr`=0 with `qd`=1, then release `clr` while keeping `qd`=1 for 5 clocks → all `w`=0, `running`=0, `cyc_cnt`=0. Then drop and raise `qd` → `w1`=1 on the next edge.
- Normal cycles: after start, `short`=0 and `long`=0 for 6 clocks → beat sequence w1,w2,w1,w2,w1,w2 and `cyc_cnt`=3.
- Mixed lengths: cycles requested as long, short, normal → beats w1 w2 w3 / w1 / w1 w2, with `cyc_cnt` stepping 1, 2, 3 at each cycle end.
- Stop: assert `stop` during W2 of a long-requested cycle → IDLE next clock, no W3, `cyc_cnt` unchanged. A `qd` pulse restarts at w1.
- Single step: `step`=1 with normal cycles → w1,w2 then IDLE with `cyc_cnt`=1. Each further `qd` pulse yields exactly one more cycle; a `qd` pulse while running has no effect.
- Wrap and reset mid-run: with `CNT_W`=4, run 17 normal cycles → `cyc_cnt`=1. Then `clr`=0 during W2 → IDLE and `cyc_cnt`=0 next edge.

Source files
------------

// File: rtl/beat_gen.sv
// beat_gen: beat (node) timing generator for the hardwired controller.
// Produces one-hot machine-cycle beats w1/w2/w3. Each instruction cycle is
// stretched or shortened on the controller's short/long requests. The block
// also handles run start (qd rising edge), halt (stop), single-step mode and
// a completed-cycle counter for debug display.
//
// Ports:
//   t3       in   system clock, rising edge
//   clr      in   synchronous active-low reset
//   qd       in   start button level; a rising edge starts the sequence
//   step     in   single-step mode: halt after every completed cycle
//   short    in   end the current cycle after w1 (sampled in W1 only)
//   long     in   extend the current cycle to w3 (sampled in W2 only)
//   stop     in   halt after the current beat
//   w1/w2/w3 out  beat outputs, one-hot while running, all 0 when idle
//   running  out  1 whenever a beat is active
//   cyc_cnt  out  completed instruction cycles, wraps modulo 2^CNT_W
//
// state | meaning
// IDLE  | no beat active, waiting for a qd rising edge
// W1    | first beat of a cycle
// W2    | second beat (normal and long cycles)
// W3    | third beat (long cycles only)

module beat_gen #(
  parameter int CNT_W = 16
) (
  input  logic             t3,
  input  logic             clr,
  input  logic             qd,
  input  logic             step,
  input  logic             short,
  input  logic             long,
  input  logic             stop,
  output logic             w1,
  output logic             w2,
  output logic             w3,
  output logic             running,
  output logic [CNT_W-1:0] cyc_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W1   = 2'd1,
    W2   = 2'd2,
    W3   = 2'd3
  } state_t;

  state_t state;
  state_t nxt;
  logic   qd_q;
  logic   qd_start;
  logic   cyc_done;

  assign qd_start = qd & ~qd_q;

  // cyc_done marks the beat that closes an instruction cycle; it is still
  // asserted when stop or step also ends the run on that same edge.
  always_comb begin
    nxt      = state;
    cyc_done = 1'b0;
    case (state)
      IDLE: begin
        if (qd_start) nxt = W1;
      end
      W1: begin
        if (stop) begin
          nxt      = IDLE;
          cyc_done = short;
        end else if (short) begin
          cyc_done = 1'b1;
          nxt      = step ? IDLE : W1;
        end else begin
          nxt = W2;
        end
      end
      W2: begin
        if (stop) begin
          nxt      = IDLE;
          cyc_done = ~long;
        end else if (long) begin
          nxt = W3;
        end else begin
          cyc_done = 1'b1;
          nxt      = step ? IDLE : W1;
        end
      end
      W3: begin
        cyc_done = 1'b1;
        nxt      = (stop | step) ? IDLE : W1;
      end
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state, so they line up with
  // the state register. qd_q resets high so a button held through reset
  // must be released and pressed again to start.
  always_ff @(posedge t3) begin
    if (!clr) begin
      state   <= IDLE;
      qd_q    <= 1'b1;
      w1      <= 1'b0;
      w2      <= 1'b0;
      w3      <= 1'b0;
      running <= 1'b0;
      cyc_cnt <= '0;
    end else begin
      state   <= nxt;
      qd_q    <= qd;
      w1      <= (nxt == W1);
      w2      <= (nxt == W2);
      w3      <= (nxt == W3);
      running <= (nxt != IDLE);
      if (cyc_done) cyc_cnt <= cyc_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_beat_gen.sv
module tb_beat_gen;

  localparam int CNT_W = 4;

  // beats packed as {running, w1, w2, w3}
  localparam logic [3:0] B_IDLE = 4'b0000;
  localparam logic [3:0] B_W1   = 4'b1100;
  localparam logic [3:0] B_W2   = 4'b1010;
  localparam logic [3:0] B_W3   = 4'b1001;

  logic             t3;
  logic             clr;
  logic             qd;
  logic             step;
  logic             short;
  logic             long;
  logic             stop;
  logic             w1;
  logic             w2;
  logic             w3;
  logic             running;
  logic [CNT_W-1:0] cyc_cnt;

  int n_vec;
  int n_bad;

  beat_gen #(.CNT_W(CNT_W)) dut (
    .t3      (t3),
    .clr     (clr),
    .qd      (qd),
    .step    (step),
    .short   (short),
    .long    (long),
    .stop    (stop),
    .w1      (w1),
    .w2      (w2),
    .w3      (w3),
    .running (running),
    .cyc_cnt (cyc_cnt)
  );

  initial t3 = 1'b0;
  always #5 t3 = ~t3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge t3);
    #1;
  endtask

  // one clock, then check beats and count
  task automatic cyc(input string tag, input logic [3:0] eb, input int ec);
    tick();
    chk({tag, ".beats"}, {28'd0, running, w1, w2, w3}, {28'd0, eb});
    chk({tag, ".cnt"}, {28'd0, cyc_cnt}, ec);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    clr = 1'b0; qd = 1'b1; step = 1'b0; short = 1'b0; long = 1'b0; stop = 1'b0;

    // reset with qd held, then hold qd through release
    cyc("rst", B_IDLE, 0);
    clr = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("hold.beats", {28'd0, running, w1, w2, w3}, {28'd0, B_IDLE});
    chk("hold.cnt", {28'd0, cyc_cnt}, 0);
    qd = 1'b0;
    cyc("release", B_IDLE, 0);
    qd = 1'b1;
    cyc("start", B_W1, 0);
    qd = 1'b0;

    // normal cycles
    cyc("n1", B_W2, 0);
    cyc("n2", B_W1, 1);
    cyc("n3", B_W2, 1);
    cyc("n4", B_W1, 2);
    cyc("n5", B_W2, 2);
    cyc("n6", B_W1, 3);

    // long, short, short+long (short wins), normal
    long = 1'b1;
    cyc("l1", B_W2, 3);
    cyc("l2", B_W3, 3);
    long = 1'b0;
    cyc("l3", B_W1, 4);
    short = 1'b1;
    cyc("s1", B_W1, 5);
    long = 1'b1;
    cyc("sl", B_W1, 6);
    short = 1'b0; long = 1'b0;
    cyc("m1", B_W2, 6);
    cyc("m2", B_W1, 7);

    // stop in W2 of a long cycle: no W3, no count
    long = 1'b1;
    cyc("st1", B_W2, 7);
    stop = 1'b1;
    cyc("st2", B_IDLE, 7);
    stop = 1'b0; long = 1'b0;
    cyc("st3", B_IDLE, 7);
    qd = 1'b1;
    cyc("st4", B_W1, 7);
    qd = 1'b0;
    // stop in W3 still completes the cycle
    long = 1'b1;
    cyc("st5", B_W2, 7);
    cyc("st6", B_W3, 7);
    stop = 1'b1;
    cyc("st7", B_IDLE, 8);
    stop = 1'b0; long = 1'b0;
    // stop in W1 without short: no count
    qd = 1'b1;
    cyc("st8", B_W1, 8);
    qd = 1'b0; stop = 1'b1;
    cyc("st9", B_IDLE, 8);
    stop = 1'b0;

    // single step
    step = 1'b1; qd = 1'b1;
    cyc("sp1", B_W1, 8);
    qd = 1'b0;
    cyc("sp2", B_W2, 8);
    cyc("sp3", B_IDLE, 9);
    cyc("sp4", B_IDLE, 9);
    qd = 1'b1;
    cyc("sp5", B_W1, 9);
    qd = 1'b0;
    cyc("sp6", B_W2, 9);
    qd = 1'b1;
    cyc("sp7", B_IDLE, 10);
    qd = 1'b0;
    cyc("sp8", B_IDLE, 10);
    qd = 1'b1;
    cyc("sp9", B_W1, 10);
    qd = 1'b0;
    cyc("sp10", B_W2, 10);
    cyc("sp11", B_IDLE, 11);
    step = 1'b0;

    // reset, then wrap the 4-bit counter with 17 normal cycles
    clr = 1'b0;
    cyc("rst2", B_IDLE, 0);
    clr = 1'b1;
    cyc("rst2b", B_IDLE, 0);
    qd = 1'b1;
    cyc("wstart", B_W1, 0);
    qd = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      cyc("wrap.w2", B_W2, (i - 1) % 16);
      cyc("wrap.w1", B_W1, i % 16);
    end
    cyc("wend", B_W2, 1);
    clr = 1'b0;
    cyc("rstmid", B_IDLE, 0);
    clr = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
